// File: rtl/fifo_wr_side_rdptr_rx_pkg.sv
// Shared types and helpers for the write-side read-pointer receiver.
// Gray helpers work on 32-bit zero-extended values; callers size-cast the result.
package fifo_pkg;

    function automatic int unsigned PTR_W(input int unsigned aw);
        return aw + 1;
    endfunction

    typedef enum logic {
        HOLD,
        RUN
    } rx_state_t;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave narrow codes unaffected.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        b = b ^ (b >> 16);
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_side_rdptr_rx_if.sv
// Bus between the write unit and the read-pointer receiver.
interface fifo_wr_side_rdptr_rx_if
    import fifo_pkg::*;
#(
    parameter int unsigned AW = 4
);
    localparam int unsigned PW = PTR_W(AW);

    logic [PW-1:0] rd_ptr_gray;
    logic [PW-1:0] wr_ptr;
    logic          wren;
    logic          err_clr;
    logic [PW-1:0] rd_ptr_sync;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] free_cnt;
    logic          ovf;
    logic          ptr_err;
    logic          ready;

    modport master (
        output rd_ptr_gray, wr_ptr, wren, err_clr,
        input  rd_ptr_sync, full, almost_full, free_cnt, ovf, ptr_err, ready
    );

    modport slave (
        input  rd_ptr_gray, wr_ptr, wren, err_clr,
        output rd_ptr_sync, full, almost_full, free_cnt, ovf, ptr_err, ready
    );
endinterface

// File: rtl/fifo_wr_side_rdptr_rx_sync.sv
// Multi-stage flop chain for clock-domain crossing of a Gray-coded bus.
module sync_bus_ff #(
    parameter int unsigned W      = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [STAGES-1:0][W-1:0] stg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stg <= '0;
        else     stg <= {stg[STAGES-2:0], d};
    end

    assign q = stg[STAGES-1];
endmodule

// File: rtl/fifo_wr_side_rdptr_rx.sv
// Write-domain receiver: synchronizes the Gray read pointer and derives
// full / almost_full / free count plus sticky overflow and pointer-error flags.
module fifo_wr_side_rdptr_rx
    import fifo_pkg::*;
#(
    parameter int unsigned AW           = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned AFULL_THRESH = 2
) (
    input logic                    wrclk,
    input logic                    wrrst,
    fifo_wr_side_rdptr_rx_if.slave bus
);
    localparam int unsigned   PW    = PTR_W(AW);
    localparam logic [PW-1:0] DEPTH = PW'(2 ** AW);
    localparam int unsigned   CW    = $clog2(SYNC_STAGES + 1);

    logic [PW-1:0] gray_s;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] used;
    logic [PW-1:0] free_raw;
    logic          full_raw;
    logic          ready;
    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ptr_err_q;

    sync_bus_ff #(
        .W      (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (wrclk),
        .rst (wrrst),
        .d   (bus.rd_ptr_gray),
        .q   (gray_s)
    );

    always_ff @(posedge wrclk or posedge wrrst) begin
        if (wrrst) rd_ptr_q <= '0;
        else       rd_ptr_q <= PW'(gray2bin(32'(gray_s)));
    end

    always_ff @(posedge wrclk or posedge wrrst) begin
        if (wrrst) begin
            state_q <= HOLD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Leave HOLD on the (SYNC_STAGES+1)-th edge, when the first real pointer lands.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HOLD: begin
                if (cnt_q == CW'(SYNC_STAGES)) state_d = RUN;
                else                           cnt_d   = cnt_q + 1'b1;
            end
            RUN:     state_d = RUN;
            default: state_d = HOLD;
        endcase
    end

    assign ready = (state_q == RUN);

    // Modulo-2**(AW+1) subtraction absorbs pointer wrap-around.
    always_comb begin
        used     = bus.wr_ptr - rd_ptr_q;
        free_raw = DEPTH - used;
        full_raw = (used == DEPTH);
    end

    always_ff @(posedge wrclk or posedge wrrst) begin
        if (wrrst) begin
            ovf_q     <= 1'b0;
            ptr_err_q <= 1'b0;
        end else begin
            if (bus.wren && bus.full) ovf_q <= 1'b1;
            else if (bus.err_clr)     ovf_q <= 1'b0;
            if (ready && (used > DEPTH)) ptr_err_q <= 1'b1;
            else if (bus.err_clr)        ptr_err_q <= 1'b0;
        end
    end

    assign bus.rd_ptr_sync = rd_ptr_q;
    assign bus.full        = !ready || full_raw;
    assign bus.free_cnt    = ready ? free_raw : '0;
    assign bus.almost_full = !ready || (free_raw <= PW'(AFULL_THRESH));
    assign bus.ovf         = ovf_q;
    assign bus.ptr_err     = ptr_err_q;
    assign bus.ready       = ready;
endmodule

// File: tb/tb_fifo_wr_side_rdptr_rx.sv
// Randomized and directed bench for fifo_wr_side_rdptr_rx against a queue-based reference model.
module tb_fifo_wr_side_rdptr_rx;
    localparam int AW = 4;

    logic wrclk = 1'b0;
    logic wrrst = 1'b1;

    fifo_wr_side_rdptr_rx_if #(.AW(AW)) bus ();

    fifo_wr_side_rdptr_rx #(
        .AW           (4),
        .SYNC_STAGES  (2),
        .AFULL_THRESH (2)
    ) dut (
        .wrclk (wrclk),
        .wrrst (wrrst),
        .bus   (bus)
    );

    always #5 wrclk = ~wrclk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: history of Gray values seen at each edge since reset.
    int gq[$];
    int edges;
    int m_rs;
    bit m_ovf, m_perr;
    int e_rs, e_free;
    bit e_full, e_af, e_ready;

    function automatic int g2b(input int g);
        for (int b = 0; b < 32; b++)
            if ((b ^ (b >> 1)) == g) return b;
        return 0;
    endfunction

    function automatic int used_now();
        return (int'(bus.wr_ptr) - m_rs + 32) % 32;
    endfunction

    task automatic compute_exp();
        int u;
        u       = used_now();
        e_ready = (edges >= 3);
        e_rs    = m_rs;
        e_full  = !e_ready || (u == 16);
        e_free  = e_ready ? (16 - u + 32) % 32 : 0;
        e_af    = !e_ready || (e_free <= 2);
    endtask

    task automatic tick();
        int u;
        compute_exp();
        u = used_now();
        if (bus.wren && e_full) m_ovf = 1'b1;
        else if (bus.err_clr)   m_ovf = 1'b0;
        if (e_ready && u > 16)  m_perr = 1'b1;
        else if (bus.err_clr)   m_perr = 1'b0;
        gq.push_back(int'(bus.rd_ptr_gray));
        @(posedge wrclk);
        #1;
        edges++;
        m_rs = (gq.size() >= 3) ? g2b(gq[gq.size()-3]) : 0;
        compute_exp();
    endtask

    task automatic do_reset();
        wrrst = 1'b1;
        #1;
        edges  = 0;
        gq.delete();
        m_rs   = 0;
        m_ovf  = 1'b0;
        m_perr = 1'b0;
        compute_exp();
    endtask

    task automatic settle();
        #1;
        compute_exp();
    endtask

    task automatic test_reset();
        bus.wr_ptr = '0; bus.rd_ptr_gray = '0; bus.wren = 1'b0; bus.err_clr = 1'b0;
        do_reset();
        n_total += 4;
        if (bus.ready !== 1'b0) $display("FAIL reset_ready got %0d expected 0", bus.ready); else n_pass++;
        if (bus.full !== 1'b1) $display("FAIL reset_full got %0d expected 1", bus.full); else n_pass++;
        if (bus.free_cnt !== 5'd0) $display("FAIL reset_free got %0d expected 0", bus.free_cnt); else n_pass++;
        if ({bus.ovf, bus.ptr_err, bus.almost_full} !== 3'b001)
            $display("FAIL reset_flags got %b expected 001", {bus.ovf, bus.ptr_err, bus.almost_full});
        else n_pass++;
        #1 wrrst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_total += 4;
            if (bus.ready !== e_ready) $display("FAIL warmup_ready edge %0d got %0d expected %0d", k, bus.ready, e_ready); else n_pass++;
            if (bus.full !== e_full) $display("FAIL warmup_full edge %0d got %0d expected %0d", k, bus.full, e_full); else n_pass++;
            if (int'(bus.free_cnt) !== e_free) $display("FAIL warmup_free edge %0d got %0d expected %0d", k, bus.free_cnt, e_free); else n_pass++;
            if (bus.almost_full !== e_af) $display("FAIL warmup_af edge %0d got %0d expected %0d", k, bus.almost_full, e_af); else n_pass++;
        end
        n_total++;
        if (bus.free_cnt !== 5'd16) $display("FAIL run_free got %0d expected 16", bus.free_cnt); else n_pass++;
    endtask

    task automatic test_full();
        bus.wr_ptr = 5'b10000;
        settle();
        n_total += 3;
        if (bus.full !== e_full || e_full !== 1'b1) $display("FAIL full_at16 got %0d expected %0d", bus.full, e_full); else n_pass++;
        if (int'(bus.free_cnt) !== e_free) $display("FAIL free_at16 got %0d expected %0d", bus.free_cnt, e_free); else n_pass++;
        if (bus.almost_full !== e_af) $display("FAIL af_at16 got %0d expected %0d", bus.almost_full, e_af); else n_pass++;
        bus.wr_ptr = 5'd14;
        settle();
        n_total += 3;
        if (bus.full !== e_full) $display("FAIL full_at14 got %0d expected %0d", bus.full, e_full); else n_pass++;
        if (int'(bus.free_cnt) !== e_free) $display("FAIL free_at14 got %0d expected %0d", bus.free_cnt, e_free); else n_pass++;
        if (bus.almost_full !== e_af) $display("FAIL af_at14 got %0d expected %0d", bus.almost_full, e_af); else n_pass++;
    endtask

    task automatic test_latency();
        bus.wr_ptr = 5'd16;
        bus.rd_ptr_gray = 5'b00001;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_total += 2;
            if (int'(bus.rd_ptr_sync) !== e_rs) $display("FAIL latency_rs edge %0d got %0d expected %0d", k, bus.rd_ptr_sync, e_rs); else n_pass++;
            if (bus.full !== e_full) $display("FAIL latency_full edge %0d got %0d expected %0d", k, bus.full, e_full); else n_pass++;
        end
        n_total++;
        if (int'(bus.free_cnt) !== e_free) $display("FAIL latency_free got %0d expected %0d", bus.free_cnt, e_free); else n_pass++;
    endtask

    task automatic test_wrap();
        bus.wr_ptr = 5'b00011;
        bus.rd_ptr_gray = 5'b10001;
        repeat (3) tick();
        n_total += 3;
        if (int'(bus.rd_ptr_sync) !== e_rs) $display("FAIL wrap_rs got %0d expected %0d", bus.rd_ptr_sync, e_rs); else n_pass++;
        if (int'(bus.free_cnt) !== e_free) $display("FAIL wrap_free got %0d expected %0d", bus.free_cnt, e_free); else n_pass++;
        if (bus.full !== e_full) $display("FAIL wrap_full got %0d expected %0d", bus.full, e_full); else n_pass++;
    endtask

    task automatic test_overflow();
        bus.wr_ptr = 5'd14;
        settle();
        n_total++;
        if (bus.full !== e_full) $display("FAIL ovf_pre_full got %0d expected %0d", bus.full, e_full); else n_pass++;
        bus.wren = 1'b1;
        tick();
        n_total++;
        if (bus.ovf !== m_ovf) $display("FAIL ovf_set got %0d expected %0d", bus.ovf, m_ovf); else n_pass++;
        bus.err_clr = 1'b1;
        tick();
        n_total++;
        if (bus.ovf !== m_ovf) $display("FAIL ovf_set_wins got %0d expected %0d", bus.ovf, m_ovf); else n_pass++;
        bus.wren = 1'b0;
        tick();
        n_total++;
        if (bus.ovf !== m_ovf) $display("FAIL ovf_clear got %0d expected %0d", bus.ovf, m_ovf); else n_pass++;
        bus.err_clr = 1'b0;
    endtask

    task automatic test_ptr_err();
        bus.wr_ptr = '0;
        bus.rd_ptr_gray = 5'b00001;
        repeat (4) tick();
        n_total += 2;
        if (bus.ptr_err !== m_perr) $display("FAIL ptr_err_set got %0d expected %0d", bus.ptr_err, m_perr); else n_pass++;
        if (int'(bus.free_cnt) !== e_free) $display("FAIL ptr_err_free got %0d expected %0d", bus.free_cnt, e_free); else n_pass++;
        do_reset();
        n_total += 4;
        if (bus.ptr_err !== 1'b0) $display("FAIL midrst_ptr_err got %0d expected 0", bus.ptr_err); else n_pass++;
        if (bus.ready !== 1'b0) $display("FAIL midrst_ready got %0d expected 0", bus.ready); else n_pass++;
        if (bus.full !== 1'b1) $display("FAIL midrst_full got %0d expected 1", bus.full); else n_pass++;
        if (bus.rd_ptr_sync !== 5'd0) $display("FAIL midrst_rs got %0d expected 0", bus.rd_ptr_sync); else n_pass++;
        #1 wrrst = 1'b0;
    endtask

    task automatic test_random();
        int rb;
        rb = 0;
        bus.wr_ptr = '0; bus.rd_ptr_gray = '0; bus.wren = 1'b0; bus.err_clr = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 80; k++) begin
            rb = (rb + int'($urandom_range(0, 2))) % 32;
            bus.rd_ptr_gray = 5'(rb ^ (rb >> 1));
            bus.wr_ptr      = 5'((rb + int'($urandom_range(0, 17))) % 32);
            bus.wren        = 1'($urandom_range(0, 1));
            bus.err_clr     = ($urandom_range(0, 7) == 0);
            tick();
            n_total += 7;
            if (int'(bus.rd_ptr_sync) !== e_rs) $display("FAIL rnd_rs cyc %0d got %0d expected %0d", k, bus.rd_ptr_sync, e_rs); else n_pass++;
            if (bus.full !== e_full) $display("FAIL rnd_full cyc %0d got %0d expected %0d", k, bus.full, e_full); else n_pass++;
            if (int'(bus.free_cnt) !== e_free) $display("FAIL rnd_free cyc %0d got %0d expected %0d", k, bus.free_cnt, e_free); else n_pass++;
            if (bus.almost_full !== e_af) $display("FAIL rnd_af cyc %0d got %0d expected %0d", k, bus.almost_full, e_af); else n_pass++;
            if (bus.ovf !== m_ovf) $display("FAIL rnd_ovf cyc %0d got %0d expected %0d", k, bus.ovf, m_ovf); else n_pass++;
            if (bus.ptr_err !== m_perr) $display("FAIL rnd_ptr_err cyc %0d got %0d expected %0d", k, bus.ptr_err, m_perr); else n_pass++;
            if (bus.ready !== e_ready) $display("FAIL rnd_ready cyc %0d got %0d expected %0d", k, bus.ready, e_ready); else n_pass++;
        end
    endtask

    initial begin
        bus.wr_ptr = '0; bus.rd_ptr_gray = '0; bus.wren = 1'b0; bus.err_clr = 1'b0;
        #1;
        test_reset();
        test_full();
        test_latency();
        test_wrap();
        test_overflow();
        test_ptr_err();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
